play_sequencer: RTL and testbench
=================================

# play_sequencer

Note sequencer for the electric piano. It turns the selected mode into a note stream for the tone generator. In auto modes it walks the per-song note ROM with tick-accurate durations and inter-note gaps. In manual mode it converts single keypad presses into timed notes. It sits between the mode controller, keypad scanner, song ROM and buzzer tone generator.

## Interface
- TICK_DIV, 3_125_000: clk cycles per duration tick (62.5 ms at 50 MHz)
- GAP_CYCLES, 250_000: silent cycles inserted after every auto-play note
- MANUAL_TICKS, 4: ticks a manual note sounds
- ADDR_W, 8: ROM address width per song

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- current_mode  in  3  0 = manual, 1–4 = song 0–3, 5–7 unused
- mode_switch  in  1  one-cycle pulse; current_mode is valid in the same cycle
- key_pulse  in  16  one-cycle keypad press pulses, bit i = key i
- rom_song  out  2  song select to ROM
- rom_addr  out  ADDR_W  note address to ROM
- rom_data  in  12  [11:6] note code (0 = rest, 63 = end), [5:0] duration in ticks; synchronous ROM, 1-cycle latency
- note_code  out  6  note to tone generator
- note_valid  out  1  tone enable
- playing  out  1  auto-play active
- song_done  out  1  one-cycle pulse at end of song

## Operation
- States:
  - MANUAL: reset state.
  - IDLE: silent.
  - FETCH: rom_addr presented.
  - WAIT: ROM latency cycle.
  - PLAY: note sounding.
  - GAP: silence after a note.
  - DONE: end of song.
- mode_switch has highest priority in every state.
  - current_mode = 1–4: rom_song <= mode−1, rom_addr <= 0, go to FETCH. Any note in progress is cut: note_valid <= 0.
  - current_mode = 0: go to MANUAL, note_valid <= 0.
  - current_mode = 5–7: go to IDLE, note_valid <= 0.
- FETCH→WAIT is unconditional.
- WAIT samples rom_data.
  - Code 63: go to DONE.
  - Otherwise: note_code <= code, note_valid <= (code != 0), duration counter loaded with max(dur, 1)·TICK_DIV, go to PLAY.
- PLAY holds until the duration counter expires. Then note_valid <= 0, go to GAP.
- GAP holds GAP_CYCLES cycles. Then rom_addr <= rom_addr+1, go to FETCH.
  - If rom_addr = 2^ADDR_W−1, go to DONE instead; the address never wraps.
- DONE: song_done = 1 for one cycle, then IDLE. Songs do not loop.
- playing = 1 exactly in FETCH, WAIT, PLAY and GAP.
- MANUAL:
  - A key_pulse with exactly one bit i set, and i not in mode-key mask 16'h8889, loads note_code <= i+1 and note_valid <= 1 for MANUAL_TICKS·TICK_DIV cycles.
  - A new valid press while a note sounds retriggers: new code, counter reloaded.
  - Multi-bit or masked presses are ignored.
  - key_pulse is ignored outside MANUAL and in any cycle where mode_switch = 1.
- Duration arithmetic: the counter is wide enough for 63·TICK_DIV, with no overflow at the parameter defaults.

## Timing
- Reset (async, any state): state = MANUAL; rom_song = 0, rom_addr = 0, note_code = 0, note_valid = 0, playing = 0, song_done = 0; all counters cleared.
- Let edge E be the edge that samples mode_switch.
  - rom_addr = 0 after E.
  - rom_data is sampled at E+2.
  - note_valid/note_code are valid after E+2.
- An auto note sounds exactly dur·TICK_DIV cycles.
- Silence between consecutive auto notes is GAP_CYCLES + 2 cycles (gap + FETCH + WAIT).
- Manual: press sampled at edge K → note_valid = 1 after K, for exactly MANUAL_TICKS·TICK_DIV cycles.
- song_done is asserted the cycle after the end marker is sampled.
- All outputs are registered.

## Test plan
(Parameters for all scenarios: TICK_DIV = 4, GAP_CYCLES = 2, MANUAL_TICKS = 2.)
- Reset mid-PLAY:
  - Stimulus: assert rst_n = 0 while a note sounds.
  - Response: all outputs go to 0 immediately; after release, a press of key 5 gives note_code = 6, note_valid = 1 for 8 cycles.
- Song playback:
  - Stimulus: mode_switch with mode = 2, ROM song 1 = {code 10 dur 3, rest dur 1, code 63}.
  - Response:
    - note_valid = 1 after E+2 for 12 cycles, note_code = 10.
    - Then 4 silent cycles, then the rest: note_valid = 0 for 4 cycles.
    - song_done pulses once; playing falls with it.
- Abort mid-note:
  - Stimulus: mode_switch with mode = 0 during PLAY.
  - Response: note_valid = 0 the next cycle, playing = 0, state MANUAL.
- Manual filtering and retrigger:
  - Stimulus: key_pulse = 16'h0008, then 16'h0006, then 16'h0004.
  - Response: the first two produce no note; the third gives note_code = 3. A second 16'h0004 four cycles later extends the note to 12 cycles total.
- Duration edge cases:
  - Stimulus: rom_data duration 0, then rom_addr reaching 255 with no end marker.
  - Response: the zero-duration note plays 4 cycles; after address 255 the sequencer goes to DONE and song_done pulses; rom_addr stays at 255.
- Simultaneous events:
  - Stimulus: mode_switch (mode 1) and key_pulse 16'h0002 in the same cycle while in MANUAL.
  - Response: the key is ignored, rom_song = 0, FETCH starts.

Source files
------------

// File: rtl/play_sequencer.sv
// play_sequencer: turns the selected mode into a timed note stream.
// Auto modes walk the song ROM (note, duration, gap); manual mode turns
// single keypad presses into fixed-length notes.
module play_sequencer #(
  parameter int TICK_DIV     = 3_125_000,
  parameter int GAP_CYCLES   = 250_000,
  parameter int MANUAL_TICKS = 4,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        current_mode,
  input  logic              mode_switch,
  input  logic [15:0]       key_pulse,
  output logic [1:0]        rom_song,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [5:0]        note_code,
  output logic              note_valid,
  output logic              playing,
  output logic              song_done
);

  // One counter serves note duration, gap and manual note length, so it is
  // sized for the largest of the three.
  localparam int DUR_MAX = 63 * TICK_DIV;
  localparam int MAN_MAX = MANUAL_TICKS * TICK_DIV;
  localparam int CNT_MAX = (DUR_MAX > MAN_MAX) ?
                           ((DUR_MAX > GAP_CYCLES) ? DUR_MAX : GAP_CYCLES) :
                           ((MAN_MAX > GAP_CYCLES) ? MAN_MAX : GAP_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TICK_LOAD = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0]  MAN_LOAD  = CNT_W'(MAN_MAX);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [15:0]       MODE_KEYS = 16'h8889;
  localparam logic [5:0]        END_CODE  = 6'd63;

  typedef enum logic [2:0] {
    S_MANUAL, S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_GAP, S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        rom_song_reg, rom_song_next;
  logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
  logic [5:0]        note_code_reg, note_code_next;
  logic              note_valid_reg, note_valid_next;
  logic              playing_reg, playing_next;
  logic              song_done_reg, song_done_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic       key_ok;
  logic [5:0] key_code;
  logic [5:0] dur_eff;

  // Keypad decode: accept only a single, non-mode key and encode it as i+1.
  always_comb begin
    key_code = 6'd0;
    for (int i = 0; i < 16; i++) begin
      if (key_pulse[i]) key_code = 6'(i + 1);
    end
    key_ok = (key_pulse != 16'd0) &&
             ((key_pulse & (key_pulse - 16'd1)) == 16'd0) &&
             ((key_pulse & MODE_KEYS) == 16'd0);
    // A zero duration still sounds for one tick.
    dur_eff = (rom_data[5:0] == 6'd0) ? 6'd1 : rom_data[5:0];
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_MANUAL;
      rom_song_reg   <= 2'd0;
      rom_addr_reg   <= '0;
      note_code_reg  <= 6'd0;
      note_valid_reg <= 1'b0;
      playing_reg    <= 1'b0;
      song_done_reg  <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      rom_song_reg   <= rom_song_next;
      rom_addr_reg   <= rom_addr_next;
      note_code_reg  <= note_code_next;
      note_valid_reg <= note_valid_next;
      playing_reg    <= playing_next;
      song_done_reg  <= song_done_next;
      cnt_reg        <= cnt_next;
    end
  end

  // Next-state logic; mode_switch overrides whatever the current state does.
  always_comb begin
    state_next      = state_reg;
    rom_song_next   = rom_song_reg;
    rom_addr_next   = rom_addr_reg;
    note_code_next  = note_code_reg;
    note_valid_next = note_valid_reg;
    cnt_next        = cnt_reg;

    if (mode_switch) begin
      note_valid_next = 1'b0;
      cnt_next        = '0;
      if (current_mode == 3'd0) begin
        state_next = S_MANUAL;
      end else if (current_mode <= 3'd4) begin
        state_next    = S_FETCH;
        rom_song_next = 2'(current_mode - 3'd1);
        rom_addr_next = '0;
      end else begin
        state_next = S_IDLE;
      end
    end else begin
      case (state_reg)
        S_MANUAL: begin
          if (key_ok) begin
            note_code_next  = key_code;
            note_valid_next = 1'b1;
            cnt_next        = MAN_LOAD;
          end else if (note_valid_reg) begin
            if (cnt_reg <= CNT_ONE) begin
              note_valid_next = 1'b0;
              cnt_next        = '0;
            end else begin
              cnt_next = cnt_reg - CNT_ONE;
            end
          end
        end
        S_FETCH: state_next = S_WAIT;
        S_WAIT: begin
          if (rom_data[11:6] == END_CODE) begin
            state_next = S_DONE;
          end else begin
            note_code_next  = rom_data[11:6];
            note_valid_next = (rom_data[11:6] != 6'd0);
            cnt_next        = CNT_W'(dur_eff) * TICK_LOAD;
            state_next      = S_PLAY;
          end
        end
        S_PLAY: begin
          if (cnt_reg <= CNT_ONE) begin
            note_valid_next = 1'b0;
            cnt_next        = GAP_LOAD;
            state_next      = S_GAP;
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt_reg <= CNT_ONE) begin
            cnt_next = '0;
            // The address saturates: the last slot ends the song.
            if (rom_addr_reg == '1) begin
              state_next = S_DONE;
            end else begin
              rom_addr_next = rom_addr_reg + ADDR_ONE;
              state_next    = S_FETCH;
            end
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = state_reg;
      endcase
    end

    playing_next   = (state_next == S_FETCH) || (state_next == S_WAIT) ||
                     (state_next == S_PLAY)  || (state_next == S_GAP);
    song_done_next = (state_next == S_DONE);
  end

  assign rom_song   = rom_song_reg;
  assign rom_addr   = rom_addr_reg;
  assign note_code  = note_code_reg;
  assign note_valid = note_valid_reg;
  assign playing    = playing_reg;
  assign song_done  = song_done_reg;

endmodule

// File: tb/tb_play_sequencer.sv
// Bench for play_sequencer: a behavioural song ROM plus a timeline model
// built from note/duration/gap rules, and a remaining-cycles model for keys.
module tb_play_sequencer;

  localparam int TICK = 4;
  localparam int GAP  = 2;
  localparam int MANT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  current_mode = 3'd0;
  logic        mode_switch = 1'b0;
  logic [15:0] key_pulse = 16'd0;
  logic [1:0]  rom_song;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data = 12'd0;
  logic [5:0]  note_code;
  logic        note_valid, playing, song_done;

  play_sequencer #(.TICK_DIV(TICK), .GAP_CYCLES(GAP), .MANUAL_TICKS(MANT), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .current_mode(current_mode), .mode_switch(mode_switch),
    .key_pulse(key_pulse), .rom_song(rom_song), .rom_addr(rom_addr), .rom_data(rom_data),
    .note_code(note_code), .note_valid(note_valid), .playing(playing), .song_done(song_done)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM, one cycle of latency.
  logic [11:0] rom [4][256];
  always @(posedge clk) rom_data <= rom[rom_song][rom_addr];

  int passed = 0;
  int total  = 0;

  // Manual-mode model: cycles of sound left and the code being sounded.
  int         mrem = 0;
  logic [5:0] mcode = 6'd0;
  bit         in_manual = 1'b1;

  typedef struct packed {
    logic       v;
    logic [5:0] c;
    logic       p;
    logic       d;
  } exp_t;
  exp_t tr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic push(input int n, input logic v, input logic [5:0] c, input logic p, input logic d);
    exp_t e;
    e.v = v; e.c = c; e.p = p; e.d = d;
    for (int i = 0; i < n; i++) tr.push_back(e);
  endtask

  // Expected per-cycle outputs after the mode_switch edge, from the song content.
  task automatic build_trace(input int s);
    int addr;
    logic [5:0] code;
    int dur;
    tr.delete();
    addr = 0;
    push(2, 1'b0, 6'd0, 1'b1, 1'b0);
    forever begin
      code = rom[s][addr][11:6];
      if (code == 6'd63) begin
        push(1, 1'b0, 6'd0, 1'b0, 1'b1);
        break;
      end
      dur = int'(rom[s][addr][5:0]);
      if (dur == 0) dur = 1;
      push(dur * TICK, code != 6'd0, code, 1'b1, 1'b0);
      push(GAP, 1'b0, 6'd0, 1'b1, 1'b0);
      if (addr == 255) begin
        push(1, 1'b0, 6'd0, 1'b0, 1'b1);
        break;
      end
      addr++;
      push(2, 1'b0, 6'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic chk_entry(input string tag, input exp_t e);
    chk({tag, "_valid"}, 32'(note_valid), 32'(e.v));
    chk({tag, "_playing"}, 32'(playing), 32'(e.p));
    chk({tag, "_done"}, 32'(song_done), 32'(e.d));
    if (e.v) chk({tag, "_code"}, 32'(note_code), 32'(e.c));
  endtask

  // Full playback of mode m, optionally with a key pressed on the switch edge.
  task automatic play_song(input int m, input logic [15:0] key, input string tag);
    build_trace(m - 1);
    current_mode = 3'(m); mode_switch = 1'b1; key_pulse = key;
    @(negedge clk);
    mode_switch = 1'b0; key_pulse = 16'd0; in_manual = 1'b0;
    chk({tag, "_song"}, 32'(rom_song), 32'(m - 1));
    chk({tag, "_addr0"}, 32'(rom_addr), 32'd0);
    for (int k = 0; k < tr.size(); k++) begin
      if (k > 0) @(negedge clk);
      chk_entry(tag, tr[k]);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_entry({tag, "_idle"}, '0);
    end
    $display("song mode=%0d cycles=%0d end_addr=%0d", m, tr.size(), rom_addr);
  endtask

  task automatic pulse_mode(input int m);
    current_mode = 3'(m); mode_switch = 1'b1;
    @(negedge clk);
    mode_switch = 1'b0;
    in_manual = (m == 0);
    mrem = 0;
  endtask

  // One manual-mode cycle: press (or not) on the next edge and compare.
  task automatic manual_cycle(input logic [15:0] key, input string tag);
    int ones;
    int idx;
    key_pulse = key;
    @(negedge clk);
    key_pulse = 16'd0;
    ones = $countones(key);
    idx = 0;
    for (int i = 0; i < 16; i++) if (key[i]) idx = i;
    if (in_manual && ones == 1 && !(idx == 0 || idx == 3 || idx == 7 || idx == 11 || idx == 15)) begin
      mrem = MANT * TICK;
      mcode = 6'(idx + 1);
    end else if (mrem > 0) begin
      mrem--;
    end
    chk({tag, "_valid"}, 32'(note_valid), 32'(mrem > 0));
    chk({tag, "_playing"}, 32'(playing), 32'd0);
    if (mrem > 0) chk({tag, "_code"}, 32'(note_code), 32'(mcode));
    $display("manual key=%04h valid=%0d code=%0d", key, note_valid, note_code);
  endtask

  initial begin
    int len;
    logic [5:0] c;
    logic [15:0] k;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 256; a++) begin
        c = 6'($urandom_range(1, 62));
        if ($urandom_range(0, 4) == 0) c = 6'd0;
        rom[s][a] = {c, 6'($urandom_range(0, 3))};
      end
    len = $urandom_range(1, 5);
    rom[0][len] = {6'd63, 6'd0};
    len = $urandom_range(1, 6);
    rom[2][len] = {6'd63, 6'd5};
    rom[1][0] = {6'd10, 6'd3};
    rom[1][1] = {6'd0, 6'd1};
    rom[1][2] = {6'd63, 6'd0};
    rom[3][0] = {6'd20, 6'd0};

    // Reset state.
    #12;
    chk("rst_song", 32'(rom_song), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_code", 32'(note_code), 32'd0);
    chk("rst_valid", 32'(note_valid), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_done", 32'(song_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while a note sounds.
    pulse_mode(2);
    repeat (3) @(negedge clk);
    chk("midplay_valid", 32'(note_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(note_valid), 32'd0);
    chk("arst_code", 32'(note_code), 32'd0);
    chk("arst_playing", 32'(playing), 32'd0);
    chk("arst_done", 32'(song_done), 32'd0);
    chk("arst_song", 32'(rom_song), 32'd0);
    chk("arst_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_manual = 1'b1; mrem = 0;
    manual_cycle(16'h0020, "key5");
    repeat (9) manual_cycle(16'h0000, "key5_hold");

    // Song 1 with rest and end marker.
    play_song(2, 16'h0000, "song1");

    // Abort mid-note.
    pulse_mode(2);
    repeat (4) @(negedge clk);
    chk("abort_pre_valid", 32'(note_valid), 32'd1);
    pulse_mode(0);
    chk("abort_valid", 32'(note_valid), 32'd0);
    chk("abort_playing", 32'(playing), 32'd0);
    manual_cycle(16'h0004, "abort_manual");
    repeat (8) manual_cycle(16'h0000, "abort_hold");

    // Filtering and retrigger.
    manual_cycle(16'h0008, "masked");
    manual_cycle(16'h0006, "multi");
    manual_cycle(16'h0004, "key2");
    repeat (3) manual_cycle(16'h0000, "key2_hold");
    manual_cycle(16'h0004, "retrig");
    repeat (9) manual_cycle(16'h0000, "retrig_hold");

    // Key with mode_switch in the same cycle, then song 0.
    play_song(1, 16'h0002, "song0");

    // Keys in IDLE are ignored.
    pulse_mode(6);
    chk("idle_playing", 32'(playing), 32'd0);
    for (int i = 0; i < 4; i++) manual_cycle(16'h0001 << $urandom_range(0, 15), "idle_key");

    // Random manual presses.
    pulse_mode(0);
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0, 1: k = 16'h0000;
        2: k = 16'h0001 << $urandom_range(0, 15);
        default: k = 16'($urandom);
      endcase
      manual_cycle(k, "rand_key");
    end

    // Random song, then the unterminated song that runs to address 255.
    play_song(3, 16'h0000, "song2");
    play_song(4, 16'h0000, "song3");
    chk("song3_addr_hold", 32'(rom_addr), 32'd255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
